cache_controller: RTL and testbench

Miss-handling sequencer for the 4-set, 4-way write-back data cache. Sits between the CPU memory stage, the cache, and a word-serial main-memory port. On a cache miss it stalls the CPU, writes back the dirty victim line if the cache flags one, fetches the missing line beat by beat into a line buffer, and pulses `update` so the cache installs it. Hits and memory-mapped I/O pass through with no stall.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_controller.sv | 119 +++++++++++
 tb/tb_cache_controller.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the data cache and its miss-handling sequencer.
package cache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int BYTE_OFF_W = 2;                     // byte offset inside a word
    localparam int BEAT_W     = 2;                     // word index inside a line
    localparam int OFFSET_W   = BEAT_W + BYTE_OFF_W;   // byte offset inside a line
    localparam int TAG_W      = ADDR_W - OFFSET_W;     // line base address width

    // Word 0 sits in the least significant slot.
    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        WRITEBACK,
        FETCH,
        UPDATE
    } cache_ctrl_state_t;

    // Byte address of one beat of a line.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0]  base,
                                                    input logic [BEAT_W-1:0] beat);
        return {base, beat, {BYTE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_controller.sv
// Miss-handling sequencer: stalls the CPU on a cacheable miss, writes back a
// dirty victim, fetches the missing line beat by beat and strobes the install.
//
// Memory handshake: a beat is offered while mem_req is high; mem_addr,
// mem_we and mem_wdata are registered and held until the edge on which
// mem_ack is sampled high, which completes the beat (write accepted or
// mem_rdata valid). mem_ack while mem_req is low is ignored.
module cache_controller
    import cache_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_READ2,
    input  logic              MEM_WRITE2,
    input  logic [ADDR_W-1:0] addr,
    input  logic              hit,
    input  logic              miss,
    input  logic              addr_is_io,
    input  logic              evict,
    input  logic [ADDR_W-1:0] evicted_addr,
    input  line_t             wb_line,
    output line_t             fill_line,
    output logic              update,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    cache_ctrl_state_t state, state_next;
    logic [BEAT_W-1:0] beat, beat_next;
    logic [TAG_W-1:0]  victim_tag, victim_tag_next;
    line_t             victim_line, victim_line_next;

    logic access, start, ack, last_beat;

    // hit is implied by !miss; the low address bits never leave the line.
    logic unused_ok;
    assign unused_ok = &{1'b0, hit, addr[OFFSET_W-1:0], evicted_addr[OFFSET_W-1:0]};

    assign access    = MEM_READ2 | MEM_WRITE2;
    assign start     = miss & access & ~addr_is_io;
    assign ack       = mem_ack & mem_req;
    assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, beat counter and victim latch selection.
    always_comb begin
        state_next       = state;
        beat_next        = beat;
        victim_tag_next  = victim_tag;
        victim_line_next = victim_line;
        case (state)
            IDLE: if (start) state_next = EVAL;
            EVAL: begin
                beat_next = '0;
                if (evict) begin
                    victim_tag_next  = evicted_addr[ADDR_W-1:OFFSET_W];
                    victim_line_next = wb_line;
                    state_next       = WRITEBACK;
                end else begin
                    state_next = FETCH;
                end
            end
            WRITEBACK: if (ack) begin
                beat_next = beat + 1'b1;
                if (last_beat) state_next = FETCH;
            end
            FETCH: if (ack) begin
                beat_next = beat + 1'b1;
                if (last_beat) state_next = UPDATE;
            end
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: beat counter, victim latch, line buffer and registered memory port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            beat        <= '0;
            victim_tag  <= '0;
            victim_line <= '0;
            fill_line   <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            beat        <= beat_next;
            victim_tag  <= victim_tag_next;
            victim_line <= victim_line_next;
            if (state == FETCH && ack) fill_line[beat] <= mem_rdata;
            mem_req <= (state_next == WRITEBACK) || (state_next == FETCH);
            mem_we  <= (state_next == WRITEBACK);
            if (state_next == WRITEBACK) begin
                mem_addr  <= beat_addr(victim_tag_next, beat_next);
                mem_wdata <= victim_line_next[beat_next];
            end else if (state_next == FETCH) begin
                mem_addr  <= beat_addr(addr[ADDR_W-1:OFFSET_W], beat_next);
            end
        end
    end

    // Outputs decoded from state; the miss-detect cycle stalls before EVAL is entered.
    always_comb begin
        update = (state == UPDATE);
        stall  = (state != IDLE) || start;
    end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: a word-serial memory responder pops expected
// beats from a queue, and each scenario checks stall length and the fill line.
module tb_cache_controller;
    import cache_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              MEM_READ2, MEM_WRITE2;
    logic [ADDR_W-1:0] addr;
    logic              hit, miss, addr_is_io, evict;
    logic [ADDR_W-1:0] evicted_addr;
    line_t             wb_line, fill_line;
    logic              update, stall, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata, mem_rdata;
    logic              mem_ack;

    // {we, addr, data}: data is write data for writes, returned data for reads
    logic [64:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    cache_controller dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ2(MEM_READ2), .MEM_WRITE2(MEM_WRITE2),
        .addr(addr), .hit(hit), .miss(miss), .addr_is_io(addr_is_io), .evict(evict),
        .evicted_addr(evicted_addr), .wb_line(wb_line), .fill_line(fill_line),
        .update(update), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Clock.
    always #5 CLK = ~CLK;

    task automatic drive_quiet();
        MEM_READ2 = 0; MEM_WRITE2 = 0; addr = '0; hit = 0; miss = 0; addr_is_io = 0;
        evict = 0; evicted_addr = '0; wb_line = '0; mem_rdata = '0; mem_ack = 0;
    endtask

    task automatic test_reset();
        drive_quiet();
        RESET = 1;
        repeat (2) @(negedge CLK);
        tests_run++;
        if (update !== 0 || mem_req !== 0 || mem_we !== 0 || mem_addr !== 0 ||
            mem_wdata !== 0 || fill_line !== '0 || stall !== 0) begin
            tests_failed++;
            $display("FAIL reset_values: upd=%b req=%b we=%b addr=%h wd=%h fill=%h stall=%b, required all zero",
                     update, mem_req, mem_we, mem_addr, mem_wdata, fill_line, stall);
        end
        // stall is purely combinational even while reset is held
        miss = 1; MEM_READ2 = 1; #1;
        tests_run++;
        if (stall !== 1) begin
            tests_failed++;
            $display("FAIL reset_stall_eq: stall=%b required 1", stall);
        end
        drive_quiet();
        @(negedge CLK);
        RESET = 0;
        @(negedge CLK);
    endtask

    // No memory traffic and no stall for a few cycles of the given request.
    task automatic check_passthrough(input string name);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            tests_run++;
            if (stall !== 0 || mem_req !== 0) begin
                tests_failed++;
                $display("FAIL %s: stall=%b mem_req=%b, required 0 0", name, stall, mem_req);
            end
        end
        drive_quiet();
    endtask

    task automatic test_read_hit();
        @(negedge CLK);
        addr = 32'h0000_0040; MEM_READ2 = 1; hit = 1; miss = 0;
        check_passthrough("read_hit");
    endtask

    task automatic test_io_store();
        @(negedge CLK);
        addr = 32'h1100_0000; MEM_WRITE2 = 1; hit = 0; miss = 1; addr_is_io = 1;
        check_passthrough("io_store");
    endtask

    task automatic run_miss(input string name, input logic [31:0] a, input logic dirty,
                            input logic [31:0] vaddr, input line_t wbl, input line_t rdl,
                            input int period, input logic is_store);
        int stall_cnt, upd_cnt, wait_cnt, exp_stall;
        logic [64:0] e;
        bit done;
        exp_stall = 2 + 4 * period + (dirty ? 4 * period : 0);
        if (dirty)
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, vaddr[31:4], 2'(i), 2'b00, wbl[i]});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, a[31:4], 2'(i), 2'b00, rdl[i]});

        @(negedge CLK);
        addr = a; MEM_READ2 = !is_store; MEM_WRITE2 = is_store; miss = 1; hit = 0;
        #1;
        tests_run++;
        if (stall !== 1) begin
            tests_failed++;
            $display("FAIL %s_detect: stall=%b required 1", name, stall);
        end
        @(negedge CLK);
        evict = dirty; evicted_addr = vaddr; wb_line = wbl;
        stall_cnt = 0; upd_cnt = 0; wait_cnt = 0; done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            if (cyc == 1) evict = 0;
            mem_ack = 0;
            if (stall) stall_cnt++;
            if (mem_req) begin
                wait_cnt++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL %s_extra_beat: addr=%h we=%b, required no request", name, mem_addr, mem_we);
                end else begin
                    e = exp_q[0];
                    if ({mem_we, mem_addr} !== e[64:32] || (e[64] && mem_wdata !== e[31:0])) begin
                        tests_failed++;
                        $display("FAIL %s_beat: we=%b addr=%h wd=%h, required we=%b addr=%h wd=%h",
                                 name, mem_we, mem_addr, mem_wdata, e[64], e[63:32], e[31:0]);
                    end
                    if (wait_cnt == period) begin
                        wait_cnt = 0;
                        mem_ack = 1;
                        mem_rdata = e[64] ? 32'hDEAD_BEEF : e[31:0];
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (update) begin
                upd_cnt++;
                tests_run++;
                if (fill_line !== rdl) begin
                    tests_failed++;
                    $display("FAIL %s_fill: fill=%h required %h", name, fill_line, rdl);
                end
                // cache installs the line and reports a hit from here on
                miss = 0; hit = 1; MEM_READ2 = 0; MEM_WRITE2 = 0;
                done = 1;
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s_timeout: no update within budget, required one", name);
        end
        @(negedge CLK);
        mem_ack = 0;
        tests_run++;
        if (update !== 0 || stall !== 0 || mem_req !== 0) begin
            tests_failed++;
            $display("FAIL %s_idle: upd=%b stall=%b req=%b, required 0 0 0", name, update, stall, mem_req);
        end
        tests_run++;
        if (stall_cnt != exp_stall || upd_cnt != 1) begin
            tests_failed++;
            $display("FAIL %s_stall_len: stall=%0d upd=%0d, required stall=%0d upd=1",
                     name, stall_cnt, upd_cnt, exp_stall);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_beats_left: %0d beats not seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
        drive_quiet();
    endtask

    task automatic test_clean_miss();
        run_miss("clean_miss", 32'h0000_1234, 1'b0, '0, '0,
                 {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 1'b0);
    endtask

    task automatic test_dirty_miss();
        run_miss("dirty_miss", 32'h0000_5678, 1'b1, 32'h0000_2050,
                 {32'h44, 32'h33, 32'h22, 32'h11},
                 {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1, 1'b0);
    endtask

    task automatic test_slow_ack();
        run_miss("slow_ack", 32'h0000_7A00, 1'b0, '0, '0,
                 {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 3, 1'b1);
    endtask

    task automatic test_back_to_back();
        line_t wbl, rdl;
        logic d;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) begin
                wbl[i] = $urandom;
                rdl[i] = $urandom;
            end
            d = 1'($urandom_range(0, 1));
            run_miss("b2b", $urandom, d, $urandom, wbl, rdl, $urandom_range(1, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_fetch();
        int upd_seen;
        @(negedge CLK);
        addr = 32'h0000_3000; MEM_READ2 = 1; miss = 1;
        @(negedge CLK);                        // EVAL, clean victim
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            tests_run++;
            if (mem_req !== 1 || mem_addr !== (32'h0000_3000 + 32'(4 * i))) begin
                tests_failed++;
                $display("FAIL rst_fetch_beat: req=%b addr=%h, required 1 %h",
                         mem_req, mem_addr, 32'h0000_3000 + 32'(4 * i));
            end
            mem_ack = 1; mem_rdata = 32'hB0 + 32'(i);
        end
        @(negedge CLK);                        // third FETCH beat, two words captured
        tests_run++;
        if (fill_line[1] !== 32'hB1) begin
            tests_failed++;
            $display("FAIL rst_partial: word1=%h required %h", fill_line[1], 32'hB1);
        end
        drive_quiet();
        RESET = 1;
        @(negedge CLK);
        tests_run++;
        if (mem_req !== 0 || fill_line !== '0 || update !== 0 || stall !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_fetch: req=%b fill=%h upd=%b stall=%b, required 0 0 0 0",
                     mem_req, fill_line, update, stall);
        end
        RESET = 0;
        upd_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (update || mem_req) upd_seen++;
        end
        tests_run++;
        if (upd_seen != 0) begin
            tests_failed++;
            $display("FAIL rst_no_update: %0d cycles with update/req, required 0", upd_seen);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_miss();
        test_slow_ack();
        test_io_store();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
